mux_4_1_arbiter: RTL and testbench
==================================

# mux_4_1_arbiter

Round-robin arbiter that shares the transmission-gate 4:1 mux (`mux_4_1_tran`) between four requesters. It samples a 4-bit request vector, grants the mux to one requester at a time and drives the mux selects `s1`/`s0` so that data input a/b/c/d of the granted requester reaches `y`. A per-grant hold limit stops one requester from starving the others. It sits directly in front of the mux select pins; the mux data inputs stay wired to the requesters.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner keeps the mux while another request is pending; legal range 1..7.
- `CNT_W`, default 3: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset; one clock, no other clock domains.
- `req` input 4: request vector; bit 0 = a, 1 = b, 2 = c, 3 = d; level-sensitive, held high while the mux is needed.
- `gnt` output 4: one-hot grant (or all zero), registered.
- `s1` output 1: mux select MSB, registered.
- `s0` output 1: mux select LSB, registered.
- `valid` output 1: high when `gnt` is non-zero and `y` carries the owner's data.

## Operation
- Reset values: `gnt`=0000, `s1`=0, `s0`=0, `valid`=0, hold counter=0, state IDLE, round-robin pointer=3, so the first search starts at requester 0.
- Pick function: search `req` starting at pointer+1 mod 4 and wrapping; the first set bit wins. Requester indices 0..3 map to {`s1`,`s0`} = 00/01/10/11.
- IDLE: `gnt`=0, `valid`=0, and `s1`/`s0` keep their last value.
  - If `req`≠0, go to BUSY: grant the pick, set pointer to the winner, load counter=0.
- BUSY: owner = pointer.
  - Release: if `req[owner]`=0 and other requests are pending, grant the next pick in the same edge, with no idle bubble and counter=0. If no other requests are pending, return to IDLE.
  - Hold limit: if `req[owner]`=1, counter = MAX_HOLD−1 and another request is pending, rotate to the pick (owner excluded by pointer order) and set counter=0.
  - Otherwise keep the owner. The counter increments and saturates at MAX_HOLD−1. If the owner is the sole requester it keeps the grant indefinitely, with the counter saturated.
- Output relation: `s1`/`s0` always equal the encoding of the owner while `valid`=1, and `valid` equals the OR of `gnt`.
- Requests that rise and fall between edges are not seen. Only sampled values count.

## Timing
- Grant latency: a request sampled at edge k gives `gnt`/`s1`/`s0`/`valid` valid after edge k (one cycle). The mux output `y` then follows combinationally.
- Handover latency: the owner drops `req` before edge k, and the new owner is granted after edge k, with zero dead cycles.
- Simultaneous events: an owner release and new requests in the same cycle are resolved by one pick. A hold-limit expiry and an owner release in the same cycle are treated as a release.
- Boundary conditions:
  - Wrap-around: pointer 3 searches 0,1,2,3.
  - All four requesting: the grant order is strictly 0→1→2→3→0, each for MAX_HOLD cycles.
- Reset mid-operation: `rst_n` low immediately (asynchronously) clears `gnt` and `valid` and forces selects to 00. After release, operation restarts from requester 0 priority.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - the constant REQ_N=4;
  - the index-to-select encoding.
- Sub-module `mux_arb_rr_pick`: combinational rotate-priority search taking `req` and pointer, returning a found flag and a 2-bit index. The top holds the FSM, pointer, counter and output registers.
- The top-level testbench instantiates the arbiter together with `mux_4_1_tran` and checks `y` end to end.

## Test plan
- Reset and single request:
  - `rst_n` low, then high, then `req`=0100 → one cycle later `gnt`=0100, {`s1`,`s0`}=10, `valid`=1, and `y` equals input c.
- Release to idle:
  - Owner 2 drops `req` to 0000 → next cycle `gnt`=0000, `valid`=0, and selects stay 10.
- Round robin under full load:
  - `req`=1111 held with MAX_HOLD=4 → grants 0001, 0010, 0100, 1000, 0001…, each for exactly 4 cycles, with selects 00, 01, 10, 11.
- Zero-bubble handover with wrap:
  - Owner 3 drops `req` while `req`=0011 → next cycle `gnt`=0001, with no cycle of `valid`=0.
- Sole requester:
  - `req`=0010 held for 20 cycles → `gnt`=0010 throughout. Raising `req[0]` after that → `gnt`=0001 one cycle later, because the counter is already saturated.
- Reset mid-grant:
  - Pull `rst_n` low between edges while `gnt`=1000 → outputs go to 0 immediately. After release with `req`=1001, the grant goes to 0001.

Source files
------------

// File: rtl/mux_4_1_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 4:1 mux.
// Requester index i drives mux selects {s1,s0} = i.
package mux_arb_pkg;

   localparam int REQ_N = 4;

   typedef enum logic {IDLE, BUSY} state_e;

   typedef logic [1:0] idx_t;

   function automatic logic [1:0] idx_to_sel(input idx_t idx);
      return idx;
   endfunction

   function automatic logic [REQ_N-1:0] idx_to_onehot(input idx_t idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux_4_1_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The select lines also feed the 4:1 mux directly.
interface mux_arb_if;
   import mux_arb_pkg::*;

   logic [REQ_N-1:0] req;
   logic [REQ_N-1:0] gnt;
   logic             s1;
   logic             s0;
   logic             valid;

   modport master (output req, input gnt, s1, s0, valid);
   modport slave  (input req, output gnt, s1, s0, valid);
endinterface

// File: rtl/mux_4_1_arbiter_rr_pick.sv
// Combinational rotate-priority search: first set request after ptr_i, wrapping.
// Searching REQ_N positions makes the pointer's own requester the last candidate.
module mux_arb_rr_pick
   import mux_arb_pkg::*;
(
   input  logic [REQ_N-1:0] req_i,
   input  idx_t             ptr_i,
   output logic             found_o,
   output idx_t             idx_o
);

   idx_t pos;

   always_comb begin
      found_o = 1'b0;
      idx_o   = ptr_i;
      pos     = ptr_i;
      for (int k = 1; k <= REQ_N; k++) begin
         pos = ptr_i + idx_t'(k);
         if (!found_o && req_i[pos]) begin
            found_o = 1'b1;
            idx_o   = pos;
         end
      end
   end

endmodule

// File: rtl/mux_4_1_tran.sv
// Behavioural model of the transmission-gate 4:1 mux: {s1,s0} selects a/b/c/d.
module mux_4_1_tran (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic s1,
   input  logic s0,
   output logic y
);

   assign y = s1 ? (s0 ? d : c) : (s0 ? b : a);

endmodule

// File: rtl/mux_4_1_arbiter.sv
// Round-robin owner of the 4:1 mux selects with a per-grant hold limit.
// The pointer doubles as the current owner while BUSY.
module mux_4_1_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic clk,
   input  logic rst_n,
   mux_arb_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   idx_t             ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [REQ_N-1:0] gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;

   logic pick_found;
   idx_t pick_idx;
   logic others;

   mux_arb_rr_pick u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign others = |(bus.req & ~idx_to_onehot(ptr_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_found) begin
               state_d = BUSY;
               ptr_d   = pick_idx;
               cnt_d   = '0;
               gnt_d   = idx_to_onehot(pick_idx);
               sel_d   = idx_to_sel(pick_idx);
            end
         end
         BUSY: begin
            // A release takes precedence over hold-limit expiry; both reuse the same pick.
            if ((!bus.req[ptr_q] || cnt_q == CNT_MAX) && others) begin
               ptr_d = pick_idx;
               cnt_d = '0;
               gnt_d = idx_to_onehot(pick_idx);
               sel_d = idx_to_sel(pick_idx);
            end else if (!bus.req[ptr_q]) begin
               state_d = IDLE;
               cnt_d   = '0;
               gnt_d   = '0;
            end else begin
               gnt_d = idx_to_onehot(ptr_q);
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.gnt   = gnt_q;
   assign bus.s1    = sel_q[1];
   assign bus.s0    = sel_q[0];
   assign bus.valid = |gnt_q;

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Scoreboarded bench: arbiter driving the 4:1 mux, checked against a queue-fed reference model.
module tb_mux_4_1_arbiter;

   localparam int MAX_HOLD = 4;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
   } exp_t;

   logic clk;
   logic rst_n;
   logic da, db, dc, dd;
   logic y;

   mux_arb_if bus ();

   mux_4_1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux_4_1_tran u_mux (
      .a  (da),
      .b  (db),
      .c  (dc),
      .d  (dd),
      .s1 (bus.s1),
      .s0 (bus.s0),
      .y  (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // Reference model state: owner (-1 when nobody holds the mux), last winner, cycles held.
   int         m_owner;
   int         m_last;
   int         m_held;
   logic [1:0] m_sel;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int start);
      for (int k = 1; k <= 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_sel   = 2'b00;
   endtask

   task automatic model_step(input logic [3:0] r);
      logic [3:0] other;
      exp_t       e;
      if (m_owner < 0) begin
         if (r != 4'b0000) begin
            m_owner = rr_pick(r, m_last);
            m_last  = m_owner;
            m_held  = 1;
         end
      end else begin
         other = r;
         other[m_owner] = 1'b0;
         if (!r[m_owner] || (m_held >= MAX_HOLD && other != 4'b0000)) begin
            if (other != 4'b0000) begin
               m_owner = rr_pick(r, m_last);
               m_last  = m_owner;
               m_held  = 1;
            end else begin
               m_owner = -1;
            end
         end else begin
            m_held++;
         end
      end
      if (m_owner >= 0) m_sel = 2'(m_owner);
      e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.sel   = m_sel;
      e.valid = (m_owner >= 0);
      exp_q.push_back(e);
   endtask

   // Drive one sampled request vector and fresh mux data, and queue the expected response.
   task automatic cycle(input logic [3:0] r);
      @(negedge clk);
      bus.req = r;
      {da, db, dc, dd} = 4'($urandom);
      model_step(r);
   endtask

   // Monitor: compares one queued expectation just after every active edge.
   exp_t       e_mon;
   logic       y_exp;
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         case (e_mon.sel)
            2'd0: y_exp = da;
            2'd1: y_exp = db;
            2'd2: y_exp = dc;
            default: y_exp = dd;
         endcase
         check("gnt", int'(bus.gnt), int'(e_mon.gnt));
         check("sel", int'({bus.s1, bus.s0}), int'(e_mon.sel));
         check("valid", int'(bus.valid), int'(e_mon.valid));
         check("y", int'(y), int'(y_exp));
      end
   end

   initial begin
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      {da, db, dc, dd} = 4'b0000;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check("reset_gnt", int'(bus.gnt), 0);
      check("reset_valid", int'(bus.valid), 0);
      check("reset_sel", int'({bus.s1, bus.s0}), 0);
      #1 rst_n = 1'b1;

      // Single request, then release to idle with selects held.
      repeat (2) cycle(4'b0100);
      repeat (2) cycle(4'b0000);
      // Full load: strict rotation, MAX_HOLD cycles each.
      repeat (20) cycle(4'b1111);
      // Zero-bubble handover wrapping from 3 to 0.
      cycle(4'b0000);
      cycle(4'b1000);
      repeat (2) cycle(4'b0011);
      // Sole requester, then a newcomer after the counter saturated.
      repeat (20) cycle(4'b0010);
      repeat (2) cycle(4'b0011);
      // Reach owner 3, then reset asynchronously between edges.
      cycle(4'b0000);
      repeat (2) cycle(4'b1000);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_gnt", int'(bus.gnt), 0);
      check("async_rst_valid", int'(bus.valid), 0);
      check("async_rst_sel", int'({bus.s1, bus.s0}), 0);
      model_reset();
      @(negedge clk);
      bus.req = 4'b1001;
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) cycle(4'b1001);

      // Randomized traffic with a bias towards sparse and fully loaded patterns.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: cycle(4'b1111);
            1: cycle(4'b0001 << $urandom_range(0, 3));
            default: cycle(4'($urandom));
         endcase
      end

      @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
